// File: rtl/carpici_pkg.sv
// Shared types and constants for the carpici multiplier sequencer.
// State encoding, default geometry, and IEEE-754 single special values.
package carpici_pkg;

  localparam int CARPICI_WIDTH   = 32;
  localparam int CARPICI_LATENCY = 34;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;
  localparam logic [31:0] NINF = 32'hFF80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or above ptr, wrapping around.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/carpici_hakem.sv
// Shares one fixed-latency carpici multiplier among N_REQ requesters, round-robin.
// Latency: handshake at edge E0 -> rsp_valid from cycle E0+LATENCY+2; one job per LATENCY+3 cycles.
// Backpressure: rsp_ready low holds DONE with result stable; no new request is accepted until it drains.
module carpici_hakem
  import carpici_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = CARPICI_WIDTH,
  parameter int LATENCY = CARPICI_LATENCY,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_sayi1,
  input  logic [N_REQ*WIDTH-1:0] req_sayi2,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sonuc,
  output logic                   busy,
  output logic                   m_reset,
  output logic [WIDTH-1:0]       m_sayi1,
  output logic [WIDTH-1:0]       m_sayi2,
  input  logic [WIDTH-1:0]       m_sonuc
);

  localparam int CNT_W = $clog2(LATENCY) + 1;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id_q;
  logic [CNT_W-1:0] cnt;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gidx;
  logic             gany;

  rr_arbiter #(
    .N   (N_REQ),
    .IDW (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    m_reset   = 1'b1;
    case (state)
      IDLE: begin
        if (!reset) req_ready = gnt;
        if (gany) state_nxt = LOAD;
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        m_reset = 1'b0;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        m_reset = 1'b0;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign rsp_id    = id_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      cnt       <= '0;
      rsp_sonuc <= '0;
      m_sayi1   <= '0;
      m_sayi2   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // Operands are frozen here; later changes on req_sayi* do not reach the multiplier.
          if (gany) begin
            m_sayi1 <= req_sayi1[int'(gidx)*WIDTH +: WIDTH];
            m_sayi2 <= req_sayi2[int'(gidx)*WIDTH +: WIDTH];
            id_q    <= gidx;
          end
        end
        LOAD: cnt <= CNT_W'(LATENCY - 1);
        RUN: begin
          if (cnt == '0) rsp_sonuc <= m_sonuc;
          else           cnt       <= cnt - 1'b1;
        end
        DONE: begin
          if (rsp_ready) rr_ptr <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/carpici_hakem.md
Name: carpici_hakem

Overview:
- Round-robin arbiter and sequencer that shares one multi-cycle `carpici` floating-point multiplier (IEEE-754 single, fixed latency, no done flag) between N requesters.
- Per request it:
  - accepts operands over a valid/ready handshake,
  - pulses the multiplier reset and holds the operands stable,
  - counts the fixed latency,
  - captures `sonuc` and returns it, tagged with the requester id.
- Sits between client datapaths and the single `carpici` instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width (IEEE-754 single)
- LATENCY, 34, cycles from multiplier reset deassertion until `m_sonuc` is valid and stable
- ID_W, 2, width of requester id; must equal clog2(N_REQ)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; at most one bit high
- req_sayi1  in  N_REQ*WIDTH  operand A per requester, slice i = [i*WIDTH +: WIDTH]
- req_sayi2  in  N_REQ*WIDTH  operand B per requester
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  requester index of the result
- rsp_sonuc  out  WIDTH  product
- busy  out  1  high in any state except IDLE
- m_reset  out  1  drives `carpici` reset
- m_sayi1  out  WIDTH  drives `carpici` sayi1
- m_sayi2  out  WIDTH  drives `carpici` sayi2
- m_sonuc  in  WIDTH  from `carpici` sonuc

Behaviour:
- Reset (synchronous): state = IDLE, rr_ptr = 0, counter = 0, rsp_valid = 0, rsp_id = 0, rsp_sonuc = 0, m_sayi1 = m_sayi2 = 0, m_reset = 1, busy = 0, req_ready = 0.
- Reset mid-operation aborts the job with no response. The requester is not re-served unless it re-requests.
- FSM has four states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - m_reset = 1.
  - Grant g = first i with req_valid[i], searching from rr_ptr upward with wrap-around.
  - req_ready[g] = 1, combinational from req_valid and rr_ptr.
  - On a handshake (req_valid[g] & req_ready[g]) at edge E0: latch slices g into m_sayi1/m_sayi2, latch g into the id register, go to LOAD.
- LOAD (exactly one cycle):
  - m_reset = 1, operands stable.
  - Go to RUN with counter = LATENCY-1.
- RUN:
  - m_reset = 0, m_sayi1/m_sayi2 held constant.
  - Counter decrements each cycle.
  - At counter == 0: capture m_sonuc into rsp_sonuc, go to DONE.
  - RUN lasts exactly LATENCY cycles.
- DONE:
  - rsp_valid = 1, rsp_id = latched g, rsp_sonuc stable, m_reset = 0.
  - On rsp_ready: rsp_valid drops next cycle, rr_ptr = (g+1) mod N_REQ, go to IDLE.
  - If rsp_ready is already high on DONE entry, rsp_valid is high for exactly one cycle.
- Latency: handshake at E0 gives rsp_valid first high in cycle E0+LATENCY+2. Throughput is one product per LATENCY+3 cycles with rsp_ready tied high.
- No request is accepted outside IDLE. req_ready is 0 in LOAD/RUN/DONE, even if req_valid is held.
- Simultaneous requests resolve round-robin: the served requester gets lowest priority next time. A requester that keeps req_valid high cannot starve the others.
- Operands are sampled only at the handshake. Later changes on req_sayi* do not affect the job in flight.
- No arithmetic in this block. NaN, Inf and zero results pass through unchanged from m_sonuc.
- Counter width is clog2(LATENCY)+1 bits and cannot wrap.

Decomposition:
- Shared package `carpici_pkg`:
  - FSM state enum {IDLE, LOAD, RUN, DONE},
  - WIDTH and default LATENCY constants,
  - FP constants: QNAN = 32'h7FC00000, PINF = 32'h7F800000, NINF = 32'hFF800000.
- One sub-module `rr_arbiter`:
  - inputs: req vector, ptr,
  - outputs: one-hot grant and encoded index,
  - purely combinational, reusable.
- Top instantiates `rr_arbiter`. The `carpici` instance stays outside the top so the multiplier can be swapped or shared.

Test Plan:
- Single request: req0 with 40000000 × 40400000 → exactly one m_reset-high LOAD cycle; rsp_valid at E0+36 (LATENCY=34); rsp_id = 0; rsp_sonuc = 40C00000.
- All four valid after reset: served in order 0,1,2,3,0. With req2 alone held afterwards, the next grant goes to 2 only after 3 and 0 (if still valid) are served.
- Backpressure: rsp_ready low for 10 cycles in DONE → rsp_valid and rsp_sonuc hold; req_ready stays 0; release → IDLE the next cycle.
- Special values via real `carpici`:
  - 7FC00000 × C12AAAAA → NaN;
  - 7F800000 × 00000000 → NaN;
  - FF800000 × 412AAAAA → FF800000.
- Reset asserted mid-RUN (cycle E0+10): next cycle state = IDLE, m_reset = 1, rsp_valid never asserts, rr_ptr = 0.
- Operand change after accept: req_sayi1 of the granted requester changes in the cycle after E0 → m_sayi1 and the result reflect the originally latched value.
